// File: rtl/pcileech_rstseq_ctl.sv
// Reset sequencer: releases COM, FIFO and PCIe resets in a fixed order with a fixed gap,
// holds PCIe on PERST#, debounces the user button and flags a long press as a config reload.
module pcileech_rstseq_ctl #(
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int STAGE_GAP        = 64,
    parameter int LONGPRESS_CYCLES = 500000000,
    parameter int CNT_W            = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       user_sw_n,
    input  logic       pcie_perst_n,
    output logic       rst_com,
    output logic       rst_fifo,
    output logic       rst_pcie,
    output logic       cfg_reload,
    output logic [2:0] seq_state
);

    localparam int GAP_W = $clog2(STAGE_GAP);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(LONGPRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_SAT   = CNT_W'(LONGPRESS_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        S_HOLD       = 3'd0,
        S_REL_COM    = 3'd1,
        S_REL_FIFO   = 3'd2,
        S_WAIT_PERST = 3'd3,
        S_RUN        = 3'd4
    } state_t;

    state_t           state;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_done;

    logic             sw_s1;
    logic             sw_s2;
    logic             perst_s1;
    logic             perst_s2;

    logic             db_level;
    logic [CNT_W-1:0] db_cnt;
    logic             db_flip;
    logic             db_next;

    logic [CNT_W-1:0] lp_cnt;

    // Button idles released (1); PERST# is treated as asserted until proven otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1    <= 1'b1;
            sw_s2    <= 1'b1;
            perst_s1 <= 1'b0;
            perst_s2 <= 1'b0;
        end else begin
            sw_s1    <= user_sw_n;
            sw_s2    <= sw_s1;
            perst_s1 <= pcie_perst_n;
            perst_s2 <= perst_s1;
        end
    end

    assign db_flip = (sw_s2 != db_level) && (db_cnt == DB_LAST);
    assign db_next = db_flip ? sw_s2 : db_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= 1'b1;
            db_cnt   <= '0;
        end else if (sw_s2 == db_level) begin
            db_cnt <= '0;
        end else if (db_flip) begin
            db_level <= sw_s2;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + CNT_W'(1);
        end
    end

    // Saturating at LONGPRESS_CYCLES stops a second pulse until the button is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_cnt     <= '0;
            cfg_reload <= 1'b0;
        end else begin
            cfg_reload <= !db_level && (lp_cnt == LP_LAST);
            if (db_level) begin
                lp_cnt <= '0;
            end else if (lp_cnt != LP_SAT) begin
                lp_cnt <= lp_cnt + CNT_W'(1);
            end
        end
    end

    assign gap_done = (gap_cnt == GAP_LAST);

    // The FSM looks at the level the debouncer adopts on this edge, so an accepted
    // press or release acts on the resets in the same cycle it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_HOLD;
            gap_cnt  <= '0;
            rst_com  <= 1'b1;
            rst_fifo <= 1'b1;
            rst_pcie <= 1'b1;
        end else if (state != S_HOLD && !db_next) begin
            state    <= S_HOLD;
            gap_cnt  <= '0;
            rst_com  <= 1'b1;
            rst_fifo <= 1'b1;
            rst_pcie <= 1'b1;
        end else begin
            case (state)
                S_HOLD: begin
                    rst_com  <= 1'b1;
                    rst_fifo <= 1'b1;
                    rst_pcie <= 1'b1;
                    gap_cnt  <= '0;
                    if (db_next) begin
                        state <= S_REL_COM;
                    end
                end
                S_REL_COM: begin
                    if (gap_done) begin
                        rst_com <= 1'b0;
                        gap_cnt <= '0;
                        state   <= S_REL_FIFO;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_REL_FIFO: begin
                    if (gap_done) begin
                        rst_fifo <= 1'b0;
                        gap_cnt  <= '0;
                        state    <= S_WAIT_PERST;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_WAIT_PERST: begin
                    if (!perst_s2) begin
                        gap_cnt <= '0;
                    end else if (gap_done) begin
                        rst_pcie <= 1'b0;
                        gap_cnt  <= '0;
                        state    <= S_RUN;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_RUN: begin
                    gap_cnt <= '0;
                    if (!perst_s2) begin
                        rst_pcie <= 1'b1;
                        state    <= S_WAIT_PERST;
                    end
                end
                default: begin
                    state    <= S_HOLD;
                    gap_cnt  <= '0;
                    rst_com  <= 1'b1;
                    rst_fifo <= 1'b1;
                    rst_pcie <= 1'b1;
                end
            endcase
        end
    end

    assign seq_state = state;

endmodule
